// File: rtl/vc_read_scheduler_pkg.sv
// Shared definitions for the VC read scheduler: direction codes,
// scheduler state encoding and default sizing.
package vc_read_scheduler_pkg;

    // Fixed VC / direction encoding used by read_en bit positions and rr_select
    localparam logic [2:0] DIR_N = 3'b000;
    localparam logic [2:0] DIR_S = 3'b001;
    localparam logic [2:0] DIR_E = 3'b010;
    localparam logic [2:0] DIR_W = 3'b011;
    localparam logic [2:0] DIR_L = 3'b100;

    localparam int NUM_VC_DEF       = 5;
    localparam int CREDIT_DEPTH_DEF = 32;
    localparam int CNT_W_DEF        = 6;
    localparam int LOCK_TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Next direction code in round-robin order, wrapping L back to N
    function automatic logic [2:0] next_code(input logic [2:0] code);
        return (code == DIR_L) ? DIR_N : code + 3'd1;
    endfunction

endpackage

// File: rtl/vc_read_scheduler_if.sv
// Bundle of the scheduler's VC-side and downstream-side signals.
// The slave modport is the scheduler; the master modport is the input
// module / environment that owns the VC buffers and downstream credits.
interface vc_read_scheduler_if #(
    parameter int NUM_VC = 5,
    parameter int CNT_W  = 6
);
    logic [NUM_VC-1:0] vc_empty;
    logic              flit_tail;
    logic              credit_in;
    logic [NUM_VC-1:0] read_en;
    logic [2:0]        rr_select;
    logic              flit_valid;
    logic              lock;
    logic [CNT_W-1:0]  credit_cnt;
    logic              credit_err;
    logic              timeout_err;

    modport master (
        output vc_empty, flit_tail, credit_in,
        input  read_en, rr_select, flit_valid, lock, credit_cnt, credit_err, timeout_err
    );

    modport slave (
        input  vc_empty, flit_tail, credit_in,
        output read_en, rr_select, flit_valid, lock, credit_cnt, credit_err, timeout_err
    );

endinterface

// File: rtl/vc_read_scheduler_rr_pick5.sv
// Combinational 5-way round-robin priority picker: searches req starting
// at ptr and wrapping L->N, returning the first requester found.
module rr_pick5
    import vc_read_scheduler_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic       gnt_valid,
    output logic [2:0] gnt_code
);

    logic [2:0] code;

    // Walk the five positions in priority order, keeping the first hit
    always_comb begin
        gnt_valid = 1'b0;
        gnt_code  = ptr;
        code      = ptr;
        for (int i = 0; i < 5; i++) begin
            if (!gnt_valid && req[code]) begin
                gnt_valid = 1'b1;
                gnt_code  = code;
            end
            code = next_code(code);
        end
    end

endmodule

// File: rtl/vc_read_scheduler.sv
// VC read scheduler: round-robin selection among the five VC buffers of one
// input module, locked per packet from head to tail, gated on downstream
// credits. read_en / rr_select / lock are combinational in the grant cycle;
// flit_valid trails read_en by one cycle to match the registered buffer read.
// 'reset' is asynchronous and active-low.
// Optional feature macro: SCHED_WATCHDOG_EN (releases a lock stalled on an
// empty VC for LOCK_TIMEOUT cycles and raises timeout_err).
module vc_read_scheduler
    import vc_read_scheduler_pkg::*;
#(
    parameter int NUM_VC       = NUM_VC_DEF,
    parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEF,
`ifdef SCHED_WATCHDOG_EN
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
`endif
    parameter int CNT_W        = CNT_W_DEF
) (
    input logic               clk,
    input logic               reset,
    vc_read_scheduler_if.slave bus
);

    sched_state_t      state_q;
    logic [2:0]        ptr_q;
    logic [2:0]        sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              gap_q;
    logic              flit_valid_q;
    logic              credit_err_q;

    logic              have_credit;
    logic [NUM_VC-1:0] req;
    logic              gnt_valid;
    logic [2:0]        gnt_code;
    logic              grant;
    logic [NUM_VC-1:0] read_en_c;
    logic [2:0]        sel_c;
    logic              lock_c;
    logic              rd;
    logic              wd_fire;

    localparam logic [NUM_VC-1:0] ONE_HOT0 = {{(NUM_VC-1){1'b0}}, 1'b1};

    assign have_credit = (cnt_q != '0);
    assign req         = ~bus.vc_empty & {NUM_VC{have_credit}};

    rr_pick5 u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_code  (gnt_code)
    );

    // Grant / read decode; everything is forced idle while reset is held so
    // the lock drops the instant reset asserts. The cycle right after a
    // multi-flit tail is a deliberate bubble (gap_q) before the next grant.
    always_comb begin
        read_en_c = '0;
        sel_c     = sel_q;
        lock_c    = 1'b0;
        grant     = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid && !gap_q) begin
                        grant     = 1'b1;
                        read_en_c = ONE_HOT0 << gnt_code;
                        sel_c     = gnt_code;
                        lock_c    = 1'b1;
                    end
                end
                XFER: begin
                    lock_c = 1'b1;
                    if (!bus.vc_empty[sel_q] && have_credit) begin
                        read_en_c = ONE_HOT0 << sel_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd = |read_en_c;

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            starving;
    logic            timeout_err_q;

    assign starving = (state_q == XFER) && bus.vc_empty[sel_q];
    assign wd_fire  = starving && (wd_q == WD_W'(LOCK_TIMEOUT - 1));

    // Count consecutive locked cycles with the locked VC empty; any other
    // cycle (including every read) restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (starving && !wd_fire) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
            if (wd_fire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign wd_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Scheduler FSM: pointer advance, lock capture, release on tail or timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= DIR_N;
            sel_q        <= DIR_N;
            gap_q        <= 1'b0;
            flit_valid_q <= 1'b0;
        end else begin
            flit_valid_q <= rd;
            gap_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        ptr_q <= next_code(gnt_code);
                        sel_q <= gnt_code;
                        if (!bus.flit_tail) begin
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (rd && bus.flit_tail) begin
                        state_q <= IDLE;
                        gap_q   <= 1'b1;
                    end else if (wd_fire) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Downstream credit counter; a credit returned into a full counter is
    // dropped and latched as an error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= CNT_W'(CREDIT_DEPTH);
            credit_err_q <= 1'b0;
        end else begin
            if (bus.credit_in && !rd) begin
                if (cnt_q == CNT_W'(CREDIT_DEPTH)) begin
                    credit_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (rd && !bus.credit_in) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign bus.read_en    = read_en_c;
    assign bus.rr_select  = sel_c;
    assign bus.lock       = lock_c;
    assign bus.flit_valid = flit_valid_q;
    assign bus.credit_cnt = cnt_q;
    assign bus.credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Self-checking bench for vc_read_scheduler: directed vectors push the
// expected granted VC into a queue; a negedge monitor pops and compares
// whenever the DUT asserts a read. A second instance with two credits
// covers the credit stall behaviour.
module tb_vc_read_scheduler;

    logic clk;
    logic reset;

    int n_checks;
    int n_pass;

    logic [2:0] exp_q[$];
    logic       read_prev;
    logic       reset_prev;

    vc_read_scheduler_if #(.NUM_VC(5), .CNT_W(6)) bus ();
    vc_read_scheduler_if #(.NUM_VC(5), .CNT_W(2)) bus2 ();

    vc_read_scheduler #(.NUM_VC(5), .CREDIT_DEPTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vc_read_scheduler #(.NUM_VC(5), .CREDIT_DEPTH(2), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the main DUT; exp_code < 0 means no read
    task automatic apply_stimulus(input logic [4:0] empty, input logic tail, input logic credit,
                                  input int exp_code);
        @(posedge clk);
        #1;
        bus.vc_empty  = empty;
        bus.flit_tail = tail;
        bus.credit_in = credit;
        if (exp_code >= 0) exp_q.push_back(3'(exp_code));
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle of inputs on the two-credit DUT
    task automatic apply_stimulus2(input logic [4:0] empty, input logic tail, input logic credit);
        @(posedge clk);
        #1;
        bus2.vc_empty  = empty;
        bus2.flit_tail = tail;
        bus2.credit_in = credit;
        @(negedge clk);
        #1;
    endtask

    // Monitor: every read must match the next expected grant; flit_valid
    // must echo the previous cycle's read
    always @(negedge clk) begin
        logic [2:0] code;
        if (reset) begin
            if (bus.read_en != 5'b0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_read", 32'(bus.read_en), 32'h0);
                end else begin
                    code = exp_q.pop_front();
                    check_output("read_en", 32'(bus.read_en), 32'(5'b00001 << code));
                    check_output("rr_select", 32'(bus.rr_select), 32'(code));
                    check_output("lock_on_read", 32'(bus.lock), 32'h1);
                end
            end
            if (reset_prev) check_output("flit_valid", 32'(bus.flit_valid), 32'(read_prev));
        end
        read_prev  = reset ? |bus.read_en : 1'b0;
        reset_prev = reset;
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        read_prev      = 1'b0;
        reset_prev     = 1'b0;
        reset          = 1'b0;
        bus.vc_empty   = 5'h1f;
        bus.flit_tail  = 1'b0;
        bus.credit_in  = 1'b0;
        bus2.vc_empty  = 5'h1f;
        bus2.flit_tail = 1'b0;
        bus2.credit_in = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check_output("rst_read_en", 32'(bus.read_en), 32'h0);
        check_output("rst_rr_select", 32'(bus.rr_select), 32'h0);
        check_output("rst_lock", 32'(bus.lock), 32'h0);
        check_output("rst_flit_valid", 32'(bus.flit_valid), 32'h0);
        check_output("rst_credit_cnt", 32'(bus.credit_cnt), 32'd32);
        check_output("rst_credit_err", 32'(bus.credit_err), 32'h0);
        check_output("rst_timeout_err", 32'(bus.timeout_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fairness: all VCs full of single-flit packets
        for (int i = 0; i < 6; i++) apply_stimulus(5'b00000, 1'b1, 1'b0, i % 5);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("fair_credit_cnt", 32'(bus.credit_cnt), 32'd26);

        // Move ptr to E with a single flit on S
        apply_stimulus(5'b11101, 1'b1, 1'b0, 1);

        // Packet lock: 3-flit packet on E while N waits
        apply_stimulus(5'b11010, 1'b0, 1'b0, 2);
        apply_stimulus(5'b11010, 1'b0, 1'b0, 2);
        check_output("lock_xfer", 32'(bus.lock), 32'h1);
        apply_stimulus(5'b11010, 1'b1, 1'b0, 2);
        apply_stimulus(5'b11110, 1'b0, 1'b0, -1);
        check_output("gap_lock", 32'(bus.lock), 32'h0);
        check_output("gap_read_en", 32'(bus.read_en), 32'h0);
        apply_stimulus(5'b11110, 1'b1, 1'b0, 0);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("lock_credit_cnt", 32'(bus.credit_cnt), 32'd21);

        // Read and credit in the same cycle leave the count unchanged
        apply_stimulus(5'b10111, 1'b1, 1'b1, 3);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("rd_credit_cnt", 32'(bus.credit_cnt), 32'd21);

        // Refill to full, then one credit too many
        for (int i = 0; i < 11; i++) apply_stimulus(5'h1f, 1'b0, 1'b1, -1);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("full_credit_cnt", 32'(bus.credit_cnt), 32'd32);
        check_output("full_credit_err", 32'(bus.credit_err), 32'h0);
        apply_stimulus(5'h1f, 1'b0, 1'b1, -1);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("ovf_credit_cnt", 32'(bus.credit_cnt), 32'd32);
        check_output("ovf_credit_err", 32'(bus.credit_err), 32'h1);

        // Reset in the middle of a W packet
        apply_stimulus(5'b10111, 1'b0, 1'b0, 3);
        apply_stimulus(5'b10111, 1'b0, 1'b0, 3);
        check_output("w_lock", 32'(bus.lock), 32'h1);
        check_output("w_credit_cnt", 32'(bus.credit_cnt), 32'd31);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("mid_rst_read_en", 32'(bus.read_en), 32'h0);
        check_output("mid_rst_lock", 32'(bus.lock), 32'h0);
        check_output("mid_rst_rr_select", 32'(bus.rr_select), 32'h0);
        check_output("mid_rst_credit_cnt", 32'(bus.credit_cnt), 32'd32);
        check_output("mid_rst_credit_err", 32'(bus.credit_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        bus.vc_empty = 5'h1f;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;

        // L locks, then starves before its tail
        apply_stimulus(5'b01111, 1'b0, 1'b0, 4);
        for (int i = 0; i < 16; i++) apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
        check_output("starve_lock", 32'(bus.lock), 32'h1);
        check_output("starve_timeout_err", 32'(bus.timeout_err), 32'h0);
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);
`ifdef SCHED_WATCHDOG_EN
        check_output("wd_lock", 32'(bus.lock), 32'h0);
        check_output("wd_timeout_err", 32'(bus.timeout_err), 32'h1);
        apply_stimulus(5'b00000, 1'b1, 1'b0, 0);
`else
        check_output("hold_lock", 32'(bus.lock), 32'h1);
        check_output("hold_timeout_err", 32'(bus.timeout_err), 32'h0);
        apply_stimulus(5'b01111, 1'b1, 1'b0, 4);
`endif
        apply_stimulus(5'h1f, 1'b0, 1'b0, -1);

        // Credit stall on the two-credit instance: 4-flit packet on S
        apply_stimulus2(5'b11101, 1'b0, 1'b0);
        check_output("c2_read1", 32'(bus2.read_en), 32'h02);
        check_output("c2_lock1", 32'(bus2.lock), 32'h1);
        check_output("c2_cnt1", 32'(bus2.credit_cnt), 32'd2);
        apply_stimulus2(5'b11101, 1'b0, 1'b0);
        check_output("c2_read2", 32'(bus2.read_en), 32'h02);
        check_output("c2_cnt2", 32'(bus2.credit_cnt), 32'd1);
        apply_stimulus2(5'b11101, 1'b0, 1'b0);
        check_output("c2_stall_read", 32'(bus2.read_en), 32'h0);
        check_output("c2_stall_lock", 32'(bus2.lock), 32'h1);
        check_output("c2_stall_cnt", 32'(bus2.credit_cnt), 32'd0);
        apply_stimulus2(5'b11101, 1'b0, 1'b1);
        check_output("c2_credit_read", 32'(bus2.read_en), 32'h0);
        apply_stimulus2(5'b11101, 1'b0, 1'b0);
        check_output("c2_read3", 32'(bus2.read_en), 32'h02);
        check_output("c2_cnt3", 32'(bus2.credit_cnt), 32'd1);
        apply_stimulus2(5'b11101, 1'b0, 1'b0);
        check_output("c2_stall2_read", 32'(bus2.read_en), 32'h0);
        check_output("c2_stall2_lock", 32'(bus2.lock), 32'h1);
        apply_stimulus2(5'b11101, 1'b0, 1'b1);
        check_output("c2_credit2_read", 32'(bus2.read_en), 32'h0);
        apply_stimulus2(5'b11101, 1'b1, 1'b0);
        check_output("c2_read4", 32'(bus2.read_en), 32'h02);
        apply_stimulus2(5'h1f, 1'b0, 1'b0);
        check_output("c2_end_lock", 32'(bus2.lock), 32'h0);
        check_output("c2_end_read", 32'(bus2.read_en), 32'h0);
        check_output("c2_end_cnt", 32'(bus2.credit_cnt), 32'd0);

        check_output("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
